// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite initiator: FSM encoding, response codes
// and the register map of the CPU's AXI-Lite slave.
package axi_lite_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_AW_W = 3'd1;
  localparam logic [2:0] ST_WR_B    = 3'd2;
  localparam logic [2:0] ST_RD_AR   = 3'd3;
  localparam logic [2:0] ST_RD_R    = 3'd4;
  localparam logic [2:0] ST_RSP     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_WR_AW_W = ST_WR_AW_W,
    S_WR_B    = ST_WR_B,
    S_RD_AR   = ST_RD_AR,
    S_RD_R    = ST_RD_R,
    S_RSP     = ST_RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] REG_CTRL       = 32'h00;
  localparam logic [31:0] REG_STATUS     = 32'h04;
  localparam logic [31:0] REG_PC         = 32'h08;
  localparam logic [31:0] REG_ALU_RESULT = 32'h0C;
  localparam logic [31:0] REG_CMP        = 32'h10;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator bridging a command/response stream to AXI-Lite.
// Optional per-phase wait timeout is enabled by defining AXIM_TIMEOUT_EN.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256,
  parameter int TO_W        = 9
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [31:0]       M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  if (TIMEOUT_CYC >= (1 << TO_W)) begin : g_to_w_check
    $error("TO_W too narrow to count TIMEOUT_CYC");
  end

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              awvalid, wvalid, bready, arvalid, rready;
  logic              aw_done, w_done;
  logic              timed_out;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic advance, expire;

  assign aw_hs = awvalid & M_AXI_AWREADY;
  assign w_hs  = wvalid  & M_AXI_WREADY;
  assign b_hs  = bready  & M_AXI_BVALID;
  assign ar_hs = arvalid & M_AXI_ARREADY;
  assign r_hs  = rready  & M_AXI_RVALID;

  // advance: the current wait state completes its handshake this cycle
  always_comb begin
    advance = 1'b0;
    unique case (state)
      S_WR_AW_W: advance = (aw_done | aw_hs) & (w_done | w_hs);
      S_WR_B:    advance = b_hs;
      S_RD_AR:   advance = ar_hs;
      S_RD_R:    advance = r_hs;
      default:   advance = 1'b0;
    endcase
  end

`ifdef AXIM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            waiting;

  assign waiting = (state == S_WR_AW_W) || (state == S_WR_B) ||
                   (state == S_RD_AR)   || (state == S_RD_R);
  assign expire  = waiting && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Counter is zero whenever a wait state is entered since it clears on every exit.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      to_cnt <= '0;
    end else if (!waiting || advance || expire) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= S_IDLE;
      addr      <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      timed_out <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr    <= cmd_addr;
            wdata   <= cmd_wdata;
            wstrb   <= cmd_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (cmd_write) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WR_AW_W;
            end else begin
              arvalid <= 1'b1;
              state   <= S_RD_AR;
            end
          end
        end
        S_WR_AW_W: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (advance) begin
            bready <= 1'b1;
            state  <= S_WR_B;
          end else if (expire) begin
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_SLVERR;
            timed_out <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_RSP;
          end
        end
        S_WR_B: begin
          if (advance || expire) begin
            bready    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= advance ? M_AXI_BRESP : RESP_SLVERR;
            timed_out <= !advance;
            rsp_valid <= 1'b1;
            state     <= S_RSP;
          end
        end
        S_RD_AR: begin
          if (advance) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RD_R;
          end else if (expire) begin
            arvalid   <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_SLVERR;
            timed_out <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_RSP;
          end
        end
        S_RD_R: begin
          if (advance || expire) begin
            rready    <= 1'b0;
            rsp_rdata <= advance ? M_AXI_RDATA : 32'h0;
            rsp_resp  <= advance ? M_AXI_RRESP : RESP_SLVERR;
            timed_out <= !advance;
            rsp_valid <= 1'b1;
            state     <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = ARESETn && (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign rsp_timeout   = timed_out;
  assign M_AXI_AWADDR  = addr;
  assign M_AXI_AWVALID = awvalid;
  assign M_AXI_WDATA   = wdata;
  assign M_AXI_WSTRB   = wstrb;
  assign M_AXI_WVALID  = wvalid;
  assign M_AXI_BREADY  = bready;
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_RREADY  = rready;

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: table of transactions against a delay-programmable
// slave model, a response scoreboard, plus hand-written reset-abort and timeout sequences.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  localparam int TO_CYC = 16;
  localparam int BUDGET = 200;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

  axi_lite_master #(.ADDR_W(32), .TIMEOUT_CYC(TO_CYC), .TO_W(9)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_to;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;

  rsp_t sb[$];
  vec_t vecs[12];
  int   nvec;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] st, input int awd, input int wd_d, input int bd,
                              input int ard, input int rd, input int rspd, input logic [1:0] br,
                              input logic [1:0] rr, input logic [31:0] rdat, input int lat,
                              input logic [31:0] erd, input logic [1:0] ers, input logic eto);
    vec_t v;
    v.write = wr; v.addr = a; v.wdata = wd; v.wstrb = st;
    v.aw_dly = awd; v.w_dly = wd_d; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rd;
    v.rsp_dly = rspd; v.bresp = br; v.rresp = rr; v.rdata = rdat;
    v.exp_lat = lat; v.exp_rdata = erd; v.exp_resp = ers; v.exp_to = eto;
    return v;
  endfunction

  task automatic slave_idle();
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   aw_c, w_c, ar_c, b_c, r_c, rsp_c, lat, exp_ar, exp_r;
    bit   done, unstable, proto_bad, pay_bad, cmd_bad;
    rsp_t first, exp;
    string tag;
    tag = $sformatf("v%0d", idx);
    aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0; rsp_c = 0; lat = -1;
    done = 0; unstable = 0; proto_bad = 0; pay_bad = 0; cmd_bad = 0;
    first = '{32'h0, 2'b00, 1'b0};

    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    M_AXI_BRESP = v.bresp; M_AXI_RRESP = v.rresp; M_AXI_RDATA = v.rdata;
    check({tag, "_cmd_ready_idle"}, cmd_ready, 1'b1);
    sb.push_back('{v.exp_rdata, v.exp_resp, v.exp_to});

    for (int cyc = 1; cyc <= BUDGET && !done; cyc++) begin
      @(negedge ACLK);
      cmd_valid = 1'b0;
      if (rsp_ready) begin
        check({tag, "_rsp_valid_cleared"}, rsp_valid, 1'b0);
        check({tag, "_cmd_ready_after"}, cmd_ready, 1'b1);
        rsp_ready = 1'b0;
        done = 1;
      end else begin
        if (M_AXI_AWVALID && M_AXI_ARVALID) proto_bad = 1;
        if (M_AXI_BREADY && M_AXI_RREADY) proto_bad = 1;
        if (M_AXI_AWVALID) begin
          aw_c++;
          if (M_AXI_AWADDR !== v.addr) pay_bad = 1;
        end
        if (M_AXI_WVALID) begin
          w_c++;
          if (M_AXI_WDATA !== v.wdata || M_AXI_WSTRB !== v.wstrb) pay_bad = 1;
        end
        if (M_AXI_ARVALID) begin
          ar_c++;
          if (M_AXI_ARADDR !== v.addr) pay_bad = 1;
        end
        if (M_AXI_BREADY) b_c++;
        if (M_AXI_RREADY) r_c++;
        M_AXI_AWREADY = M_AXI_AWVALID && (aw_c > v.aw_dly);
        M_AXI_WREADY  = M_AXI_WVALID  && (w_c  > v.w_dly);
        M_AXI_ARREADY = M_AXI_ARVALID && (ar_c > v.ar_dly);
        M_AXI_BVALID  = M_AXI_BREADY  && (b_c  > v.b_dly);
        M_AXI_RVALID  = M_AXI_RREADY  && (r_c  > v.r_dly);
        if (rsp_valid) begin
          rsp_c++;
          if (cmd_ready) cmd_bad = 1;
          if (rsp_c == 1) begin
            lat = cyc;
            first = '{rsp_rdata, rsp_resp, rsp_timeout};
          end else if (rsp_rdata !== first.rdata || rsp_resp !== first.resp ||
                       rsp_timeout !== first.to) begin
            unstable = 1;
          end
          if (rsp_c > v.rsp_dly) begin
            rsp_ready = 1'b1;
            if (sb.size() == 0) begin
              check({tag, "_scoreboard_empty"}, 1'b1, 1'b0);
            end else begin
              exp = sb.pop_front();
              check({tag, "_rsp_rdata"}, rsp_rdata, exp.rdata);
              check({tag, "_rsp_resp"}, rsp_resp, exp.resp);
              check({tag, "_rsp_timeout"}, rsp_timeout, exp.to);
            end
          end
        end
      end
    end
    if (!done) begin
      check({tag, "_completion_within_budget"}, 1'b0, 1'b1);
      rsp_ready = 1'b0;
      sb.delete();
    end
    slave_idle();

    exp_ar = v.write ? 0 : (v.exp_to ? TO_CYC : v.ar_dly + 1);
    exp_r  = (v.write || v.exp_to) ? 0 : v.r_dly + 1;
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_awvalid_cycles"}, aw_c, v.write ? v.aw_dly + 1 : 0);
    check({tag, "_wvalid_cycles"}, w_c, v.write ? v.w_dly + 1 : 0);
    check({tag, "_bready_cycles"}, b_c, v.write ? v.b_dly + 1 : 0);
    check({tag, "_arvalid_cycles"}, ar_c, exp_ar);
    check({tag, "_rready_cycles"}, r_c, exp_r);
    check({tag, "_rsp_valid_cycles"}, rsp_c, v.rsp_dly + 1);
    check({tag, "_payload_stable"}, pay_bad, 1'b0);
    check({tag, "_protocol_ok"}, proto_bad, 1'b0);
    check({tag, "_rsp_stable"}, unstable, 1'b0);
    check({tag, "_cmd_ready_low_in_rsp"}, cmd_bad, 1'b0);
  endtask

  initial begin
    ARESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    M_AXI_BRESP = '0; M_AXI_RRESP = '0; M_AXI_RDATA = '0;
    slave_idle();

    //    wr    addr            wdata          strb  aw w b ar r rsp bresp rresp rdata  lat rdata  resp  to
    vecs[0] = mk(1, REG_CTRL, 32'h1, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 3, 32'h0, 2'b00, 0);
    vecs[1] = mk(0, REG_PC, 32'h0, 4'h0, 0, 0, 0, 4, 0, 0, 2'b00, 2'b00, 32'h5, 7, 32'h5, 2'b00, 0);
    vecs[2] = mk(1, REG_STATUS, 32'hA5A5_0F0F, 4'h3, 3, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 6, 32'h0, 2'b00, 0);
    vecs[3] = mk(0, REG_CMP, 32'h0, 4'h0, 0, 0, 0, 0, 0, 5, 2'b00, 2'b10, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 2'b10, 0);
    vecs[4] = mk(1, REG_ALU_RESULT, 32'h1234_5678, 4'hC, 2, 5, 2, 0, 0, 0, 2'b11, 2'b00, 32'h0, 10, 32'h0, 2'b11, 0);
    vecs[5] = mk(0, REG_ALU_RESULT, 32'h0, 4'h0, 0, 0, 0, 0, 3, 0, 2'b00, 2'b01, 32'h0000_1234, 6, 32'h0000_1234, 2'b01, 0);
    vecs[6] = mk(1, REG_CMP, 32'hFFFF_FFFF, 4'h1, 0, 0, 0, 0, 0, 2, 2'b10, 2'b00, 32'h0, 3, 32'h0, 2'b10, 0);
    vecs[7] = mk(1, 32'hFFFF_FFFC, 32'h8000_0001, 4'hF, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 4, 32'h0, 2'b00, 0);
    vecs[8] = mk(0, REG_CTRL, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hCAFE_F00D, 3, 32'hCAFE_F00D, 2'b00, 0);
    nvec = 9;
`ifdef AXIM_TIMEOUT_EN
    vecs[9] = mk(0, REG_PC, 32'h0, 4'h0, 0, 0, 0, 1000, 0, 0, 2'b00, 2'b00, 32'h7777_7777, TO_CYC + 1, 32'h0, 2'b10, 1);
    nvec = 10;
`endif

    // Reset values while ARESETn is held low
    repeat (2) @(negedge ACLK);
    check("reset_ctrl_outputs",
          {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, busy, cmd_ready},
          8'h00);
    check("reset_rsp_fields", {rsp_rdata, rsp_resp, rsp_timeout}, 35'h0);
    check("reset_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, 64'h0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("post_reset_cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < nvec; i++) run_vec(vecs[i], i);

    // Asynchronous reset in the middle of WR_B aborts the write without a response
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = REG_STATUS;
    cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    check("abort_aw_w_valid", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
    @(negedge ACLK);
    slave_idle();
    check("abort_bready_before_reset", {M_AXI_BREADY, busy}, 2'b11);
    #2 ARESETn = 1'b0;
    #1;
    check("abort_ctrl_outputs_async",
          {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, busy, cmd_ready},
          8'h00);
    check("abort_addr_data_cleared", {M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB}, 68'h0);
    check("abort_rsp_cleared", {rsp_rdata, rsp_resp, rsp_timeout}, 35'h0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("abort_release_idle", {busy, cmd_ready, rsp_valid}, 3'b010);

    run_vec(mk(0, REG_STATUS, 32'h0, 4'h0, 0, 0, 1, 1, 1, 1, 2'b00, 2'b00, 32'h0BAD_C0DE, 5,
               32'h0BAD_C0DE, 2'b00, 0), 99);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI-Lite initiator. Turns a simple command/response stream into AXI-Lite read and write transactions.
- Used by the host-side bridge and the system bench to drive the CPU's AXI-Lite register slave: ctrl 0x00, status 0x04, pc 0x08, alu_result 0x0C, cmp 0x10.
- Issues one transaction at a time. Returns read data or the write response on the response stream.

Parameters:
- ADDR_W, 32, AXI address width; AWADDR/ARADDR driven full width.
- TIMEOUT_CYC, 256, cycles allowed per wait phase before fault completion (used only with AXIM_TIMEOUT_EN).
- TO_W, 9, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- ACLK  in  1  clock; everything rising-edge.
- ARESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  response produced by timeout.
- busy  out  1  state != IDLE.
- M_AXI_AWADDR out ADDR_W; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out ADDR_W; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- Reset values: all VALID/READY outputs 0, rsp_* 0, busy 0, address/data registers 0, state IDLE. Reset is asynchronous and aborts any transaction mid-flight with no response.
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE: cmd_ready = 1 (combinational, IDLE only). On accept, latch addr/wdata/wstrb/write.
  - Write: AWVALID = WVALID = 1 next cycle; go to WR_AW_W.
  - Read: ARVALID = 1 next cycle; go to RD_AR.
- WR_AW_W: AW and W handshake independently; aw_done and w_done flags.
  - Each VALID drops the cycle after its own handshake; the other VALID stays held, and its payload stays stable until its own handshake.
  - Both done (including the same cycle) -> WR_B with BREADY = 1.
- WR_B: on BVALID, capture BRESP, rdata = 0, BREADY = 0 -> RSP.
- RD_AR: hold ARVALID/ARADDR until ARREADY -> RD_R with RREADY = 1.
- RD_R: on RVALID, capture RDATA/RRESP, RREADY = 0 -> RSP.
- RSP: rsp_valid = 1; rsp_* held stable until rsp_ready. Then rsp_valid = 0 and go to IDLE; cmd_ready is high on that next cycle.
- Minimum latency with zero-wait slave:
  - Write: accept to rsp_valid = 3 cycles (AW/W, B, RSP).
  - Read: accept to rsp_valid = 3 cycles (AR, R, RSP).
- Never asserts BREADY/RREADY outside WR_B/RD_R. Never has AW and AR outstanding together.
- A VALID is never deasserted before its handshake, except by reset or timeout.
- Responses SLVERR/DECERR pass through unmodified; rsp_timeout = 0.

Optional Feature:
- Macro: AXIM_TIMEOUT_EN.
- Defined:
  - Counter clears on every state entry and increments each cycle in WR_AW_W, WR_B, RD_AR and RD_R.
  - When it reaches TIMEOUT_CYC: drop all AXI VALID/READY outputs, set rsp_resp = 2'b10, rsp_timeout = 1, rdata = 0, go to RSP.
  - A handshake in the same cycle as expiry wins; no timeout is taken.
- Undefined: no counter; waits indefinitely; rsp_timeout tied 0.

Decomposition:
- Package axi_lite_pkg: state encoding localparams, RESP_OKAY/EXOKAY/SLVERR/DECERR constants, register offset constants (REG_CTRL 0x00 to REG_CMP 0x10).
- No sub-module is needed. The timeout counter is inline logic under the macro.

Test Plan:
- Write addr 0x00 data 0x1 strb 0xF, zero-wait slave -> AWVALID/WVALID together, one BREADY cycle, rsp_valid 3 cycles after accept, rsp_resp 2'b00.
- Read 0x08 with slave RDATA 0x5 after ARREADY delayed 4 cycles -> ARVALID held 5 cycles with ARADDR stable, rsp_rdata 0x5, rsp_resp 2'b00.
- Write with WREADY at cycle 1 and AWREADY at cycle 4 -> WVALID drops after cycle 1, AWVALID held through cycle 4, WR_B entered once.
- Read with RRESP 2'b10, rsp_ready held low 5 cycles -> rsp_valid and rsp_resp 2'b10 stable all 5 cycles, cmd_ready 0 until consumed.
- ARESETn low during WR_B -> all outputs 0 immediately (asynchronous); after release, busy 0 and cmd_ready 1.
- AXIM_TIMEOUT_EN, TIMEOUT_CYC 16, slave never asserts ARREADY -> ARVALID drops after 16 cycles, rsp_timeout 1, rsp_resp 2'b10, rsp_rdata 0.
